// File: rtl/add_serial.sv
// ============================================================================
//  Module   : add_serial
//  Purpose  : Digit-serial unsigned adder. Adds two WIDTH-bit operands plus a
//             carry-in, DIGIT bits per clock, least-significant digit first,
//             with valid/ready handshakes on both input and output.
//             One add takes WIDTH/DIGIT digit cycles; the carry between digits
//             is held in a register.
//  Ports    : clk        rising-edge clock
//             reset      synchronous, active-high reset
//             in_valid   operands valid            in_ready   can accept operands
//             a, b       WIDTH-bit operands        cin        carry-in
//             out_valid  result valid              out_ready  consumer accepts
//             sum        a + b + cin mod 2^WIDTH   cout       carry out of MSB
//             overflow   two's-complement overflow (only with the macro below)
//  Options  : `define ADD_SERIAL_OVERFLOW_EN adds the 'overflow' output port.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module add_serial #(
  parameter int WIDTH = 16,  // operand/sum width, integer multiple of DIGIT
  parameter int DIGIT = 4    // bits added per clock, 1 <= DIGIT <= WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef ADD_SERIAL_OVERFLOW_EN
  ,
  output logic             overflow
`endif
);

  // Number of digit cycles per add and the digit counter width. A single
  // digit (DIGIT == WIDTH) still gets a 1-bit counter that simply stays at 0.
  localparam int            N    = WIDTH / DIGIT;
  localparam int            CW   = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [WIDTH-1:0]  a_q, a_d;
  logic [WIDTH-1:0]  b_q, b_d;
  logic              carry_q, carry_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [WIDTH-1:0]  sum_q, sum_d;
  logic              cout_q, cout_d;
`ifdef ADD_SERIAL_OVERFLOW_EN
  logic              ovf_q, ovf_d;
`endif

  // --------------------------------------------------------------------------
  // Digit datapath: one DIGIT-wide add of the current digit plus held carry.
  // --------------------------------------------------------------------------
  logic [31:0]      w_base;
  logic [DIGIT-1:0] w_dig_a;
  logic [DIGIT-1:0] w_dig_b;
  logic [DIGIT-1:0] w_dig_s;
  logic             w_dig_co;

  assign w_base  = 32'(cnt_q) * 32'(DIGIT);
  assign w_dig_a = a_q[w_base +: DIGIT];
  assign w_dig_b = b_q[w_base +: DIGIT];
  assign {w_dig_co, w_dig_s} = {1'b0, w_dig_a} + {1'b0, w_dig_b} + {{DIGIT{1'b0}}, carry_q};

`ifdef ADD_SERIAL_OVERFLOW_EN
  // Carry into the digit's top bit is recovered from that bit's sum:
  // s = a ^ b ^ c_in  =>  c_in = s ^ a ^ b. On the last digit this is the
  // carry into bit WIDTH-1.
  logic w_msb_ci;
  assign w_msb_ci = w_dig_s[DIGIT-1] ^ w_dig_a[DIGIT-1] ^ w_dig_b[DIGIT-1];
`endif

  // --------------------------------------------------------------------------
  // Next-state and datapath update
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
`ifdef ADD_SERIAL_OVERFLOW_EN
    ovf_d   = ovf_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = b;
          carry_d = cin;
          cnt_d   = '0;
          state_d = ST_BUSY;
        end
      end

      ST_BUSY: begin
        sum_d[w_base +: DIGIT] = w_dig_s;
        carry_d                = w_dig_co;
        if (cnt_q == LAST) begin
          // Counter holds at its terminal value; it is re-cleared on accept.
          cout_d  = w_dig_co;
`ifdef ADD_SERIAL_OVERFLOW_EN
          ovf_d   = w_msb_ci ^ w_dig_co;
`endif
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      ST_DONE: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // State and datapath registers; reset wins over any handshake.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
`ifdef ADD_SERIAL_OVERFLOW_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
`ifdef ADD_SERIAL_OVERFLOW_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign sum       = sum_q;
  assign cout      = cout_q;
`ifdef ADD_SERIAL_OVERFLOW_EN
  assign overflow  = ovf_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_add_serial.sv
// ============================================================================
//  Module   : tb_add_serial
//  Purpose  : Self-checking bench for add_serial. Three instances share the
//             input stimulus: WIDTH=16 with DIGIT=4 (main), DIGIT=16 and
//             DIGIT=1. Expected results come from plain integer addition.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_add_serial;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        out_ready;
  logic        cin;
  logic [15:0] a;
  logic [15:0] b;

  logic        in_ready_w  [3];
  logic        out_valid_w [3];
  logic        cout_w      [3];
  logic [15:0] sum_w       [3];
`ifdef ADD_SERIAL_OVERFLOW_EN
  logic        ovf_w       [3];
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  add_serial #(.WIDTH(16), .DIGIT(4)) u_dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_w[0]),
    .a(a), .b(b), .cin(cin), .out_valid(out_valid_w[0]), .out_ready(out_ready),
    .sum(sum_w[0]), .cout(cout_w[0])
`ifdef ADD_SERIAL_OVERFLOW_EN
    , .overflow(ovf_w[0])
`endif
  );

  add_serial #(.WIDTH(16), .DIGIT(16)) u_d16 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_w[1]),
    .a(a), .b(b), .cin(cin), .out_valid(out_valid_w[1]), .out_ready(out_ready),
    .sum(sum_w[1]), .cout(cout_w[1])
`ifdef ADD_SERIAL_OVERFLOW_EN
    , .overflow(ovf_w[1])
`endif
  );

  add_serial #(.WIDTH(16), .DIGIT(1)) u_d1 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_w[2]),
    .a(a), .b(b), .cin(cin), .out_valid(out_valid_w[2]), .out_ready(out_ready),
    .sum(sum_w[2]), .cout(cout_w[2])
`ifdef ADD_SERIAL_OVERFLOW_EN
    , .overflow(ovf_w[2])
`endif
  );

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic [15:0] exp_sum;
    logic        exp_cout;
    logic        exp_ovf;
  } vec_t;

  // Reference: {overflow, cout, sum} from integer addition of the operands.
  function automatic logic [17:0] model(input logic [15:0] x, input logic [15:0] y,
                                        input logic c);
    int unsigned s;
    logic        ov;
    s  = int'(x) + int'(y) + int'(c);
    ov = (x[15] == y[15]) && (s[15] != x[15]);
    return {ov, s[16], s[15:0]};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Waits for the main instance's out_valid, counting cycles after accept.
  task automatic wait_valid(output int lat);
    lat = 0;
    while (!out_valid_w[0] && lat < 40) begin
      step();
      lat++;
    end
  endtask

  // One complete add on the main instance with latency/result/handshake checks.
  task automatic do_add(input string tag, input logic [15:0] x, input logic [15:0] y,
                        input logic c, input logic [15:0] esum, input logic ecout,
                        input logic eovf);
    int lat;
    check({tag, " in_ready before accept"}, 32'(in_ready_w[0]), 32'd1);
    a = x; b = y; cin = c; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    a = ~x; b = ~y; cin = ~c;  // operands must already be latched
    wait_valid(lat);
    check({tag, " latency"}, 32'(lat), 32'd4);
    check({tag, " sum"}, 32'(sum_w[0]), 32'(esum));
    check({tag, " cout"}, 32'(cout_w[0]), 32'(ecout));
`ifdef ADD_SERIAL_OVERFLOW_EN
    check({tag, " overflow"}, 32'(ovf_w[0]), 32'(eovf));
`else
    if (eovf === 1'bx) $display("note: unknown overflow expectation");
`endif
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check({tag, " idle after handshake"}, {30'd0, in_ready_w[0], out_valid_w[0]}, 32'b10);
    check({tag, " sum held"}, 32'(sum_w[0]), 32'(esum));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global timeout");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t        vecs [7];
    logic [17:0] m;
    logic [15:0] ra, rb, hsum;
    logic        rc, hcout;
    int          lat, lats [3];
    int          exp_lat [3];

    vecs[0] = '{16'h1234, 16'h4321, 1'b1, 16'h5556, 1'b0, 1'b0};
    vecs[1] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0};
    vecs[2] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1};
    vecs[3] = '{16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0};
    vecs[4] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0};
    vecs[5] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1};
    vecs[6] = '{16'h0F0F, 16'h00F1, 1'b0, 16'h1000, 1'b0, 1'b0};
    exp_lat = '{4, 1, 16};

    // ---- reset state ----
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; cin = 1'b0; a = '0; b = '0;
    step(); step();
    for (int i = 0; i < 3; i++) begin
      check($sformatf("reset inst%0d ready/valid", i),
            {30'd0, in_ready_w[i], out_valid_w[i]}, 32'b10);
      check($sformatf("reset inst%0d sum/cout", i), {15'd0, cout_w[i], sum_w[i]}, 32'd0);
    end
    reset = 1'b0;
    step();

    // ---- table-driven vectors ----
    for (int i = 0; i < 7; i++) begin
      do_add($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].cin,
             vecs[i].exp_sum, vecs[i].exp_cout, vecs[i].exp_ovf);
    end

    // ---- randomized vectors against the model ----
    for (int i = 0; i < 24; i++) begin
      ra = 16'($urandom); rb = 16'($urandom); rc = 1'($urandom);
      m  = model(ra, rb, rc);
      do_add($sformatf("rand%0d", i), ra, rb, rc, m[15:0], m[16], m[17]);
    end

    // ---- backpressure: hold DONE, pulse in_valid ----
    a = 16'hABCD; b = 16'h1111; cin = 1'b0; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    wait_valid(lat);
    check("bp latency", 32'(lat), 32'd4);
    hsum = sum_w[0]; hcout = cout_w[0];
    check("bp sum", 32'(hsum), 32'h0000BCDE);
    for (int i = 0; i < 5; i++) begin
      a = 16'($urandom); b = 16'($urandom); in_valid = 1'(i % 2 == 0);
      step();
      check($sformatf("bp hold%0d valid/ready", i), {30'd0, out_valid_w[0], in_ready_w[0]}, 32'b10);
      check($sformatf("bp hold%0d sum/cout", i), {15'd0, cout_w[0], sum_w[0]}, {15'd0, hcout, hsum});
    end
    in_valid = 1'b0; out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check("bp release ready/valid", {30'd0, in_ready_w[0], out_valid_w[0]}, 32'b10);
    check("bp release sum held", 32'(sum_w[0]), 32'(hsum));
    repeat (6) step();
    check("bp no phantom add", {30'd0, in_ready_w[0], out_valid_w[0]}, 32'b10);

    // ---- reset on the 2nd BUSY edge ----
    repeat (20) step();  // let slower instances drain their work
    a = 16'hFFFF; b = 16'hFFFF; cin = 1'b1; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();              // first BUSY edge
    reset = 1'b1;
    step();              // second BUSY edge samples reset
    reset = 1'b0;
    check("midrst ready/valid", {30'd0, in_ready_w[0], out_valid_w[0]}, 32'b10);
    check("midrst sum/cout", {15'd0, cout_w[0], sum_w[0]}, 32'd0);
    do_add("midrst readd", 16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0, 1'b0);

    // ---- reset together with in_valid in IDLE ----
    repeat (20) step();
    reset = 1'b1; in_valid = 1'b1; a = 16'h5555; b = 16'h5555; cin = 1'b1;
    step();
    reset = 1'b0; in_valid = 1'b0;
    check("rst+valid idle", 32'(in_ready_w[0]), 32'd1);
    repeat (6) step();
    check("rst+valid not accepted", {30'd0, in_ready_w[0], out_valid_w[0]}, 32'b10);
    check("rst+valid sum", 32'(sum_w[0]), 32'd0);

    // ---- all three widths of digit side by side ----
    for (int v = 0; v < 2; v++) begin
      reset = 1'b1;
      step();
      reset = 1'b0;
      ra = (v == 0) ? 16'h8000 : 16'hFFFF;
      rb = (v == 0) ? 16'h8000 : 16'h0001;
      m  = model(ra, rb, 1'b0);
      a = ra; b = rb; cin = 1'b0; in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      lats = '{-1, -1, -1};
      for (int cyc = 1; cyc <= 24; cyc++) begin
        step();
        for (int i = 0; i < 3; i++) begin
          if (lats[i] < 0 && out_valid_w[i]) lats[i] = cyc;
        end
      end
      for (int i = 0; i < 3; i++) begin
        check($sformatf("deg v%0d inst%0d latency", v, i), 32'(lats[i]), 32'(exp_lat[i]));
        check($sformatf("deg v%0d inst%0d sum/cout", v, i),
              {15'd0, cout_w[i], sum_w[i]}, {15'd0, m[16], m[15:0]});
`ifdef ADD_SERIAL_OVERFLOW_EN
        check($sformatf("deg v%0d inst%0d overflow", v, i), 32'(ovf_w[i]), 32'(m[17]));
`endif
      end
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
        check($sformatf("deg v%0d inst%0d back to idle", v, i),
              {30'd0, in_ready_w[i], out_valid_w[i]}, 32'b10);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/add_serial.md
Name: add_serial

Overview:
- Parametrised, multi-cycle digit-serial adder; successor to the fixed 4-bit ripple adder.
- Adds two WIDTH-bit operands plus carry-in, DIGIT bits per clock, LSB digit first.
- Carry is held in a register between digits.
- Valid/ready handshakes on input and output let it sit between pipeline stages where area matters more than latency.

Parameters:
- WIDTH, 16, operand and sum width in bits; must be an integer multiple of DIGIT.
- DIGIT, 4, bits added per clock cycle; 1 <= DIGIT <= WIDTH.
- Derived: N = WIDTH/DIGIT, the number of digit cycles per add.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous reset, active-high
- in_valid  input  1  operands valid
- in_ready  output  1  block can accept operands
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B
- cin  input  1  carry-in
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts result
- sum  output  WIDTH  a + b + cin, mod 2^WIDTH
- cout  output  1  carry out of bit WIDTH-1

Behaviour:
- Single clock domain: clk. Reset is synchronous and active-high (reset), sampled on the rising edge of clk.
- Reset state:
  - state = IDLE, in_ready = 1, out_valid = 0.
  - sum = 0, cout = 0.
  - Internal operand registers, carry register and digit counter = 0.
- Reset has priority over every other input in the same cycle, including any in_valid or out_ready handshake.
- State IDLE:
  - in_ready = 1.
  - On an edge with in_valid = 1, latch a, b and cin (carry register <= cin), clear the digit counter, go to BUSY.
- State BUSY:
  - in_ready = 0, out_valid = 0.
  - Each edge adds digit k (bits k*DIGIT+DIGIT-1 .. k*DIGIT) of A and B plus the carry register.
  - The DIGIT-bit result is written into the same bit positions of sum; the carry-out of the digit goes to the carry register; k increments.
  - On the edge that processes digit N-1, cout <= that digit's carry-out and go to DONE.
- State DONE:
  - out_valid = 1, in_ready = 0.
  - sum and cout are stable until the out_valid/out_ready handshake completes.
  - On an edge with out_ready = 1, go to IDLE with out_valid = 0.
  - sum and cout keep their last values after the handshake.
- Latency and throughput:
  - out_valid rises N cycles after the accept edge.
  - The earliest next accept is the cycle after the output handshake, so one add takes at least N+2 cycles.
- Arithmetic: unsigned modulo 2^WIDTH.
  - In BUSY, only bits of digits already processed in the current add are defined in sum.
  - Consumers must use sum only while out_valid = 1.
- Boundary conditions:
  - DIGIT = WIDTH: N = 1, and the block is a registered full-width adder with handshake.
  - Counter width: clog2(N), minimum 1 bit. The terminal value is N-1; the counter never wraps past it.
  - in_valid in BUSY or DONE is ignored; no operand overwrite.
  - out_ready in IDLE or BUSY is ignored.
  - Reset mid-BUSY or in DONE discards the in-flight add. On the next cycle: IDLE, out_valid = 0, in_ready = 1, sum = 0, cout = 0.

Optional Feature:
- Macro ADD_SERIAL_OVERFLOW_EN.
- When defined:
  - Extra output port: overflow, output, 1 bit, two's-complement signed overflow.
  - It is computed on the final digit edge as the carry into bit WIDTH-1 XOR the carry out of bit WIDTH-1.
  - Reset value 0; it follows the same hold rules as cout.
- When undefined: the port is absent and there is no extra logic.

Test Plan (WIDTH=16, DIGIT=4 unless stated):
- Basic add: reset, then accept a=0x1234, b=0x4321, cin=1 -> out_valid exactly 4 cycles after the accept edge; sum=0x5556, cout=0.
- Full carry ripple: a=0xFFFF, b=0x0001, cin=0 -> sum=0x0000, cout=1. With ADD_SERIAL_OVERFLOW_EN: a=0x7FFF, b=0x0001 -> sum=0x8000, cout=0, overflow=1.
- Backpressure: hold out_ready=0 for 5 cycles in DONE -> out_valid stays 1, sum and cout unchanged, in_ready=0, in_valid pulses ignored; out_ready=1 -> IDLE next cycle, in_ready=1.
- Reset mid-operation: assert reset on the 2nd BUSY edge -> next cycle out_valid=0, in_ready=1, sum=0, cout=0; a new add of 0x0001+0x0001 then returns sum=0x0002.
- Simultaneous events: reset=1 with in_valid=1 in IDLE -> operands not accepted, state stays IDLE.
- Degenerate parameters: DIGIT=16 with a=0x8000, b=0x8000 -> out_valid 1 cycle after accept, sum=0x0000, cout=1. DIGIT=1: out_valid 16 cycles after accept.
